// File: rtl/regfile_sb.sv
// Register file with a per-register busy scoreboard, masked writeback, and two combinational read ports.
// Optional feature: define REGFILE_SB_BYPASS_EN to forward same-cycle writeback data to the read ports.
module regfile_sb #(
  parameter int unsigned N = 32,
  parameter int unsigned A = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [A-1:0] r1,
  input  logic [A-1:0] r2,
  output logic [N-1:0] v1,
  output logic [N-1:0] v2,
  output logic         b1,
  output logic         b2,
  input  logic         wf,
  input  logic [A-1:0] w1,
  input  logic [N-1:0] w,
  input  logic [N-1:0] mask,
  input  logic         iss,
  input  logic [A-1:0] iss_rd,
  output logic         iss_err,
  output logic [A:0]   pend
);

  localparam int unsigned DEPTH = 2 ** A;
  localparam int unsigned PW    = A + 1;

  logic [N-1:0]     regs_q [DEPTH];
  logic [N-1:0]     regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic             iss_err_q;
  logic             iss_err_d;
  logic [PW-1:0]    pend_q;
  logic [PW-1:0]    pend_d;

  logic             wr_en_c;
  logic [N-1:0]     merge_c;

  // $0 is never written, so it stays at its reset value of zero
  assign wr_en_c = wf && (w1 != '0);
  assign merge_c = (regs_q[w1] & ~mask) | (w & mask);

  // Next state: writeback clears busy first, then the issue checks the cleared view
  always_comb begin
    regs_d    = regs_q;
    busy_d    = busy_q;
    iss_err_d = 1'b0;
    pend_d    = '0;
    if (wr_en_c) begin
      regs_d[w1] = merge_c;
      busy_d[w1] = 1'b0;
    end
    if (iss && (iss_rd != '0)) begin
      if (busy_d[iss_rd]) begin
        iss_err_d = 1'b1;
      end else begin
        busy_d[iss_rd] = 1'b1;
      end
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      pend_d = pend_d + PW'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q    <= '0;
      iss_err_q <= 1'b0;
      pend_q    <= '0;
    end else begin
      regs_q    <= regs_d;
      busy_q    <= busy_d;
      iss_err_q <= iss_err_d;
      pend_q    <= pend_d;
    end
  end

  // Read ports; with bypass, a same-cycle write to the addressed register wins
  always_comb begin
    v1 = regs_q[r1];
    b1 = busy_q[r1];
    v2 = regs_q[r2];
    b2 = busy_q[r2];
`ifdef REGFILE_SB_BYPASS_EN
    if (wr_en_c && !rst && (r1 == w1)) begin
      v1 = merge_c;
      b1 = 1'b0;
    end
    if (wr_en_c && !rst && (r2 == w1)) begin
      v2 = merge_c;
      b2 = 1'b0;
    end
`endif
  end

  assign iss_err = iss_err_q;
  assign pend    = pend_q;

endmodule
